// File: rtl/design_mux_ctrl.sv
// Sequenced pad mux: routes one of NUM_DESIGNS design slots to the IO pads via ISOLATE/WARMUP/ACTIVE.
// Optional TEST_PATTERN_EN makes ID 2**SEL_W-1 drive an internal counter/debug pattern.
module design_mux_ctrl #(
  parameter int unsigned NUM_DESIGNS = 2,
  parameter int unsigned PADS        = 38,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned DEFAULT_ID  = 0,
  parameter int unsigned ISO_CYCLES  = 4,
  parameter int unsigned WARM_CYCLES = 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        sel_clk,
  input  logic [SEL_W-1:0]            sel_id,
  input  logic [3:0]                  debug,
  input  logic [NUM_DESIGNS*PADS-1:0] des_io_out,
  input  logic [NUM_DESIGNS*PADS-1:0] des_io_oeb,
  output logic [PADS-1:0]             io_out,
  output logic [PADS-1:0]             io_oeb,
  output logic [NUM_DESIGNS-1:0]      des_rst,
  output logic [SEL_W-1:0]            active_id,
  output logic                        switching
);

  localparam int unsigned MAX_CYC = (ISO_CYCLES > WARM_CYCLES) ? ISO_CYCLES : WARM_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [SEL_W:0]   NUM_D  = (SEL_W+1)'(NUM_DESIGNS);
  localparam logic [SEL_W-1:0] DEF_ID = SEL_W'(DEFAULT_ID);

  typedef enum logic [1:0] {ISOLATE, WARMUP, ACTIVE, PARKED} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       target_q, target_d;
  logic [NUM_DESIGNS-1:0] des_rst_q, des_rst_d;
  logic                   pad_en_q, pad_en_d;
  logic [2:0]             sync_q;
  logic                   sel_evt;
  logic                   slot_d;
  logic                   tp_en_d;

  assign sel_evt = sync_q[1] & ~sync_q[2];
  assign slot_d  = ({1'b0, target_d} < NUM_D);

  function automatic logic id_valid(input logic [SEL_W-1:0] id);
`ifdef TEST_PATTERN_EN
    return ({1'b0, id} < NUM_D) || (id == '1);
`else
    return ({1'b0, id} < NUM_D);
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    target_d = target_q;
    if (sel_evt) begin
      target_d = sel_id;
      cnt_d    = '0;
      state_d  = ISOLATE;
    end else begin
      case (state_q)
        ISOLATE: if (cnt_q == CNT_W'(ISO_CYCLES - 1)) begin
          state_d = WARMUP;
          cnt_d   = '0;
        end
        WARMUP: if (cnt_q == CNT_W'(WARM_CYCLES - 1)) begin
          state_d = id_valid(target_q) ? ACTIVE : PARKED;
          cnt_d   = '0;
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Reset and pad gating are computed from the next state so they line up with it.
  always_comb begin
    des_rst_d = '1;
    for (int unsigned k = 0; k < NUM_DESIGNS; k++) begin
      if ((state_d == WARMUP || state_d == ACTIVE) && target_d == SEL_W'(k)) begin
        des_rst_d[k] = 1'b0;
      end
    end
    pad_en_d = (state_d == ACTIVE) && slot_d;
`ifdef TEST_PATTERN_EN
    tp_en_d  = (state_d == ACTIVE) && (target_d == '1);
`else
    tp_en_d  = 1'b0;
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ISOLATE;
      cnt_q     <= '0;
      target_q  <= DEF_ID;
      des_rst_q <= '1;
      pad_en_q  <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      des_rst_q <= des_rst_d;
      pad_en_q  <= pad_en_d;
      sync_q    <= {sync_q[1:0], sel_clk};
    end
  end

`ifdef TEST_PATTERN_EN
  logic        tp_en_q;
  logic [15:0] tp_cnt_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tp_en_q  <= 1'b0;
      tp_cnt_q <= '0;
    end else begin
      tp_en_q  <= tp_en_d;
      tp_cnt_q <= tp_en_q ? tp_cnt_q + 16'd1 : '0;
    end
  end
`else
  logic unused_tp;
  assign unused_tp = ^{debug, tp_en_d};
`endif

  always_comb begin
    io_out = '1;
    io_oeb = '1;
    for (int unsigned k = 0; k < NUM_DESIGNS; k++) begin
      if (pad_en_q && target_q == SEL_W'(k)) begin
        io_out = des_io_out[k*PADS +: PADS];
        io_oeb = des_io_oeb[k*PADS +: PADS];
      end
    end
`ifdef TEST_PATTERN_EN
    if (tp_en_q) begin
      io_out[15:0]  = tp_cnt_q;
      io_out[19:16] = debug;
      io_oeb[19:0]  = '0;
    end
`endif
  end

  assign des_rst   = des_rst_q;
  assign active_id = target_q;
  assign switching = (state_q != ACTIVE);

endmodule

// File: tb/tb_design_mux_ctrl.sv
// Scoreboard bench for design_mux_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_design_mux_ctrl;

  localparam logic [37:0] S0_OUT = 38'h15_5555_5555;
  localparam logic [37:0] S1_OUT = 38'h2A_AAAA_AAAA;
  localparam logic [37:0] S0_OEB = 38'h00_0000_0000;
  localparam logic [37:0] S1_OEB = 38'h00_0F0F_0F0F;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        sel_clk;
  logic [3:0]  sel_id;
  logic [3:0]  debug;
  logic [75:0] des_io_out;
  logic [75:0] des_io_oeb;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic [1:0]  des_rst;
  logic [3:0]  active_id;
  logic        switching;

  assign des_io_out = {S1_OUT, S0_OUT};
  assign des_io_oeb = {S1_OEB, S0_OEB};

  design_mux_ctrl #(
    .NUM_DESIGNS(2), .PADS(38), .SEL_W(4), .DEFAULT_ID(0), .ISO_CYCLES(4), .WARM_CYCLES(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .sel_clk(sel_clk), .sel_id(sel_id), .debug(debug),
    .des_io_out(des_io_out), .des_io_oeb(des_io_oeb), .io_out(io_out), .io_oeb(io_oeb),
    .des_rst(des_rst), .active_id(active_id), .switching(switching)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [37:0] out;
    logic [37:0] oeb;
    logic [1:0]  rst;
    logic        sw;
    logic [3:0]  id;
    bit          chk_id;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  bit   stim_done = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic push_reset(input string nm);
    exp_t x;
    x.at = cyc; x.out = '1; x.oeb = '1; x.rst = 2'b11; x.sw = 1'b1;
    x.id = 4'd0; x.chk_id = 1'b1; x.name = nm;
    exp_q.push_back(x);
  endtask

  // k=0..3 ISOLATE, k=4..11 WARMUP, k>=12 final state (ACTIVE or PARKED)
  task automatic push_seq(input int unsigned e, input logic [3:0] id, input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      exp_t x;
      x.at = e + k; x.name = nm; x.id = id; x.chk_id = 1'b0;
      x.out = '1; x.oeb = '1; x.rst = 2'b11; x.sw = 1'b1;
      if (k >= 4 && id == 4'd0) x.rst = 2'b10;
      if (k >= 4 && id == 4'd1) x.rst = 2'b01;
      if (k >= 12) begin
        x.chk_id = 1'b1;
        if (id == 4'd0) begin
          x.out = S0_OUT; x.oeb = S0_OEB; x.sw = 1'b0;
        end else if (id == 4'd1) begin
          x.out = S1_OUT; x.oeb = S1_OEB; x.sw = 1'b0;
        end
`ifdef TEST_PATTERN_EN
        else if (id == 4'hF) begin
          x.out = {18'h3FFFF, 4'hA, 16'(k - 12)}; x.oeb = 38'h3F_FFF0_0000; x.sw = 1'b0;
        end
`endif
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic strobe(input logic [3:0] id, input int n, input string nm);
    sel_id  = id;
    sel_clk = 1'b1;
    push_seq(cyc + 3, id, n, nm);
    step(4);
    sel_clk = 1'b0;
  endtask

  initial begin
    wb_rst_i = 1'b1; sel_clk = 1'b0; sel_id = 4'd0; debug = 4'hA;
    step(1);
    push_reset("reset");
    step(1);
    wb_rst_i = 1'b0;
    push_seq(cyc, 4'd0, 13, "boot");
    step(14);
    strobe(4'd1, 13, "sw1");
    step(12);
    // first strobe is overtaken in WARMUP by a second one
    strobe(4'd1, 8, "warm1");
    step(4);
    strobe(4'd0, 13, "restart0");
    step(12);
    strobe(4'd5, 15, "park5");
    step(14);
    strobe(4'd1, 13, "sw1b");
    step(12);
    wb_rst_i = 1'b1;
    push_reset("midrst");
    step(1);
    wb_rst_i = 1'b0;
    push_seq(cyc, 4'd0, 13, "replay");
    step(14);
    strobe(4'hF, 15, "id15");
    step(14);
    stim_done = 1;
  end

  initial begin
    exp_t x;
    int unsigned guard = 0;
    while (!(stim_done && exp_q.size() == 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        x = exp_q.pop_front();
        checks++;
        if (x.at < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", x.name, x.at, cyc);
        end else if (io_out !== x.out || io_oeb !== x.oeb || des_rst !== x.rst ||
                     switching !== x.sw || (x.chk_id && active_id !== x.id)) begin
          errors++;
          $display("FAIL %s cyc=%0d got out=%h oeb=%h rst=%b sw=%b id=%0d exp out=%h oeb=%h rst=%b sw=%b id=%0d",
                   x.name, cyc, io_out, io_oeb, des_rst, switching, active_id,
                   x.out, x.oeb, x.rst, x.sw, x.id);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d expectations left, got %0d required 0", exp_q.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
